// File: rtl/ed25519_pkg.sv
// Shared constants and types for the Ed25519 point encoder.
// Field prime p = 2^255 - 19 and the inversion exponent p - 2.
package ed25519_pkg;

  localparam int unsigned N = 255;

  localparam logic [N-1:0] P         = {N{1'b1}} - N'(18);
  // 255'h7fff...ffeb
  localparam logic [N-1:0] P_MINUS_2 = P - N'(2);

  typedef enum logic [2:0] {
    StIdle,
    StInvSq,
    StInvMul,
    StMulX,
    StMulY,
    StFinal
  } state_e;

endpackage

// File: rtl/mult_modp.sv
// Modular multiplier mod 2^255-19: one-cycle latency, canonical result.
// Product is registered on en; dr pulses the following cycle.
module mult_modp
  import ed25519_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         dr,
  output logic [N-1:0] prod
);

  logic [2*N-1:0] w_prod;
  logic [N+5:0]   w_fold1;
  logic [N:0]     w_fold2;
  logic [N-1:0]   w_sub;
  logic [N-1:0]   w_red;
  logic           r_dr;
  logic [N-1:0]   r_prod;

  // 2^255 == 19 (mod p): fold the high half twice, then one conditional subtract.
  always_comb begin
    w_prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    w_fold1 = {6'b0, w_prod[N-1:0]} + {6'b0, w_prod[2*N-1:N]} * (N+6)'(19);
    w_fold2 = {1'b0, w_fold1[N-1:0]} + {{(N-5){1'b0}}, w_fold1[N+5:N]} * (N+1)'(19);
    w_sub   = w_fold2[N-1:0] - P;
    w_red   = (w_fold2 >= {1'b0, P}) ? w_sub : w_fold2[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dr   <= 1'b0;
      r_prod <= '0;
    end else begin
      r_dr <= en;
      if (en) r_prod <= w_red;
    end
  end

  assign dr   = r_dr;
  assign prod = r_prod;

endmodule

// File: rtl/point_encode.sv
// Ed25519 point encoder: (X:Y:Z) -> {x_aff[0], y_aff} via Fermat inversion
// of Z on a single shared modular multiplier.
module point_encode #(
  parameter int unsigned N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic         busy,
  output logic         done,
  output logic [N:0]   enc,
  output logic         err
);
  import ed25519_pkg::*;

  state_e       r_state, w_state_nxt;
  logic [N-1:0] r_x, w_x_nxt;
  logic [N-1:0] r_y, w_y_nxt;
  logic [N-1:0] r_z, w_z_nxt;
  logic [N-1:0] r_acc, w_acc_nxt;
  logic [7:0]   r_idx, w_idx_nxt;
  logic         r_issued, w_issued_nxt;
  logic         r_zero, w_zero_nxt;
  logic         r_done, w_done_nxt;
  logic         r_err, w_err_nxt;
  logic [N:0]   r_enc, w_enc_nxt;

  logic         w_in_mul;
  logic         w_mul_en;
  logic         w_mul_dr;
  logic         w_mul_ack;
  logic [N-1:0] w_op_a;
  logic [N-1:0] w_op_b;
  logic [N-1:0] w_prod;
  logic [N-1:0] w_x_can;
  logic [N-1:0] w_y_can;

  // Operand select; acc holds z^-1 once the inversion loop finishes.
  always_comb begin
    w_op_a   = r_acc;
    w_op_b   = r_acc;
    w_in_mul = 1'b1;
    case (r_state)
      StInvSq:  w_op_b = r_acc;
      StInvMul: w_op_b = r_z;
      StMulX:   w_op_a = r_x;
      StMulY:   w_op_a = r_y;
      default:  w_in_mul = 1'b0;
    endcase
  end

  assign w_mul_en  = w_in_mul & ~r_issued;
  assign w_mul_ack = r_issued & w_mul_dr;

  mult_modp u_mult (
    .clk   (clk),
    .rst_n (~rst),
    .en    (w_mul_en),
    .a     (w_op_a),
    .b     (w_op_b),
    .dr    (w_mul_dr),
    .prod  (w_prod)
  );

  assign w_x_can = (r_x >= P) ? (r_x - P) : r_x;
  assign w_y_can = (r_y >= P) ? (r_y - P) : r_y;

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_z_nxt      = r_z;
    w_acc_nxt    = r_acc;
    w_idx_nxt    = r_idx;
    w_issued_nxt = r_issued;
    w_zero_nxt   = r_zero;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_enc_nxt    = r_enc;

    if (w_mul_en) begin
      w_issued_nxt = 1'b1;
    end else if (w_mul_ack) begin
      w_issued_nxt = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_x_nxt      = x;
          w_y_nxt      = y;
          w_z_nxt      = z;
          w_acc_nxt    = N'(1);
          w_idx_nxt    = 8'd254;
          w_issued_nxt = 1'b0;
          w_zero_nxt   = (z == '0);
          w_state_nxt  = (z == '0) ? StFinal : StInvSq;
        end
      end
      StInvSq: begin
        if (w_mul_ack) begin
          w_acc_nxt = w_prod;
          if (P_MINUS_2[r_idx]) begin
            w_state_nxt = StInvMul;
          end else if (r_idx == 8'd0) begin
            w_state_nxt = StMulX;
          end else begin
            w_idx_nxt = r_idx - 8'd1;
          end
        end
      end
      StInvMul: begin
        if (w_mul_ack) begin
          w_acc_nxt = w_prod;
          if (r_idx == 8'd0) begin
            w_state_nxt = StMulX;
          end else begin
            w_idx_nxt   = r_idx - 8'd1;
            w_state_nxt = StInvSq;
          end
        end
      end
      StMulX: begin
        if (w_mul_ack) begin
          w_x_nxt     = w_prod;
          w_state_nxt = StMulY;
        end
      end
      StMulY: begin
        if (w_mul_ack) begin
          w_y_nxt     = w_prod;
          w_state_nxt = StFinal;
        end
      end
      StFinal: begin
        w_done_nxt  = 1'b1;
        w_err_nxt   = r_zero;
        w_enc_nxt   = r_zero ? '0 : {w_x_can[0], w_y_can};
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_acc    <= N'(1);
      r_idx    <= 8'd254;
      r_issued <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_enc    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_z      <= w_z_nxt;
      r_acc    <= w_acc_nxt;
      r_idx    <= w_idx_nxt;
      r_issued <= w_issued_nxt;
      r_zero   <= w_zero_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_enc    <= w_enc_nxt;
    end
  end

  assign busy = (r_state != StIdle);
  assign done = r_done;
  assign enc  = r_enc;
  assign err  = r_err;

endmodule
